// File: rtl/return_address_stack_pkg.sv
// Shared types for the fetch-stage return-address stack: PC/bool typedefs,
// default depth, checkpoint payload and the return-address helper.
package return_address_stack_pkg;

  localparam int unsigned PC_W              = 32;
  localparam int unsigned RAS_DEPTH_DEFAULT = 8;
  localparam int unsigned RAS_PTR_W_DEFAULT = $clog2(RAS_DEPTH_DEFAULT);
  // Calls return past the branch delay slot
  localparam int unsigned RAS_RET_OFFSET    = 8;

  typedef logic [PC_W-1:0] pc_t;
  typedef logic            bool_t;

  // Checkpoint carried down the pipe with a branch so a redirect can restore the stack
  typedef struct packed {
    logic [RAS_PTR_W_DEFAULT-1:0] ptr;
    logic [RAS_PTR_W_DEFAULT:0]   cnt;
  } ras_ckpt_t;

  // Return address pushed for a call fetched at pc (32-bit modulo)
  function automatic pc_t ras_ret_addr(input pc_t pc);
    return pc + PC_W'(RAS_RET_OFFSET);
  endfunction

endpackage

// File: rtl/return_address_stack_entry_array.sv
// DEPTH x 32 return-address register file: one write port, one async read
// port, all entries cleared by reset.
module ras_entry_array
  import return_address_stack_pkg::*;
#(
  parameter int unsigned DEPTH = RAS_DEPTH_DEFAULT,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic [PC_W-1:0]  wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output logic [PC_W-1:0]  rdata_o
);

  pc_t mem_q [DEPTH];

  // Entry storage; only the write port changes contents after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/return_address_stack.sv
// Speculative return-address stack beside the fetch quick decoder.
// Circular buffer: calls push pc+8, returns pop, overflow overwrites oldest.
// Optional feature macro RAS_CHECKPOINT_EN: flush restores the checkpointed
// top/count instead of emptying the stack.
module return_address_stack
  import return_address_stack_pkg::*;
#(
  parameter int unsigned DEPTH = RAS_DEPTH_DEFAULT,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_valid,
  input  logic             stall,
  input  logic [PC_W-1:0]  fetch_pc,
  input  logic             is_call,
  input  logic             is_return,
  output logic [PC_W-1:0]  ras_target,
  output logic             ras_valid,
  input  logic             flush,
  input  logic [PTR_W-1:0] flush_ptr,
  input  logic [PTR_W:0]   flush_cnt,
  output logic [PTR_W-1:0] cur_ptr,
  output logic [PTR_W:0]   cur_cnt
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_c;
  logic [PTR_W-1:0] waddr_c;
  pc_t              wdata_c;
  pc_t              rdata_c;
  logic             upd_c;
  logic             empty_c;
  logic [PTR_W-1:0] top_inc_c;
  logic [PTR_W-1:0] top_dec_c;
  logic [CNT_W-1:0] cnt_sat_inc_c;

  assign upd_c         = fetch_valid & ~stall & ~flush;
  assign empty_c       = (cnt_q == '0);
  assign top_inc_c     = top_q + PTR_W'(1);
  assign top_dec_c     = top_q - PTR_W'(1);
  assign cnt_sat_inc_c = (cnt_q == CNT_FULL) ? CNT_FULL : cnt_q + CNT_W'(1);

`ifndef RAS_CHECKPOINT_EN
  // Checkpoint inputs have no effect when the stack is simply emptied on flush
  logic unused_flush_ckpt;
  assign unused_flush_ckpt = ^{flush_ptr, flush_cnt};
`endif

  // Next-state for top/count and the entry write request
  always_comb begin
    top_d   = top_q;
    cnt_d   = cnt_q;
    we_c    = 1'b0;
    waddr_c = top_inc_c;
    wdata_c = ras_ret_addr(fetch_pc);
    if (flush) begin
`ifdef RAS_CHECKPOINT_EN
      top_d = flush_ptr;
      cnt_d = (flush_cnt > CNT_FULL) ? CNT_FULL : flush_cnt;
`else
      top_d = '0;
      cnt_d = '0;
`endif
    end else if (upd_c) begin
      if (is_call && is_return) begin
        if (empty_c) begin
          // Nothing to replace: behaves as a plain push
          top_d = top_inc_c;
          cnt_d = CNT_W'(1);
          we_c  = 1'b1;
        end else begin
          waddr_c = top_q;
          we_c    = 1'b1;
        end
      end else if (is_call) begin
        top_d = top_inc_c;
        cnt_d = cnt_sat_inc_c;
        we_c  = 1'b1;
      end else if (is_return && !empty_c) begin
        top_d = top_dec_c;
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Top pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  ras_entry_array #(
    .DEPTH (DEPTH)
  ) u_entries (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (we_c),
    .waddr_i (waddr_c),
    .wdata_i (wdata_c),
    .raddr_i (top_q),
    .rdata_o (rdata_c)
  );

  // Zero-latency prediction; stale entries are hidden while empty
  assign ras_target = empty_c ? '0 : rdata_c;
  assign ras_valid  = ~empty_c;
  assign cur_ptr    = top_q;
  assign cur_cnt    = cnt_q;

endmodule

// File: tb/tb_return_address_stack.sv
// Self-checking bench for return_address_stack (follows RAS_CHECKPOINT_EN).
module tb_return_address_stack;
  import return_address_stack_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_valid = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        is_call = 1'b0;
  logic        is_return = 1'b0;
  logic [31:0] ras_target;
  logic        ras_valid;
  logic        flush = 1'b0;
  logic [2:0]  flush_ptr = '0;
  logic [3:0]  flush_cnt = '0;
  logic [2:0]  cur_ptr;
  logic [3:0]  cur_cnt;

  int n_pass = 0;
  int n_total = 0;

  return_address_stack #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .stall(stall),
    .fetch_pc(fetch_pc), .is_call(is_call), .is_return(is_return),
    .ras_target(ras_target), .ras_valid(ras_valid), .flush(flush),
    .flush_ptr(flush_ptr), .flush_cnt(flush_cnt), .cur_ptr(cur_ptr), .cur_cnt(cur_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: stack as array + integer top/count
  logic [31:0] m_mem [DEPTH];
  int m_top, m_cnt;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_top = 0;
    m_cnt = 0;
  endtask

  task automatic model_step(input logic fv, st, call, ret, fl,
                            input logic [31:0] pc, input int fp, input int fc);
    if (fl) begin
`ifdef RAS_CHECKPOINT_EN
      m_top = fp;
      m_cnt = (fc > DEPTH) ? DEPTH : fc;
`else
      m_top = 0;
      m_cnt = 0;
`endif
    end else if (fv && !st) begin
      if (call && ret && m_cnt > 0) begin
        m_mem[m_top] = pc + 32'd8;
      end else if (call) begin
        m_top = (m_top + 1) % DEPTH;
        m_mem[m_top] = pc + 32'd8;
        m_cnt = (call && ret) ? 1 : ((m_cnt + 1 > DEPTH) ? DEPTH : m_cnt + 1);
      end else if (ret && m_cnt > 0) begin
        m_top = (m_top + DEPTH - 1) % DEPTH;
        m_cnt = m_cnt - 1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_model(input string tag);
    check({tag, " valid"},  32'(ras_valid), (m_cnt != 0) ? 32'd1 : 32'd0);
    check({tag, " target"}, ras_target, (m_cnt != 0) ? m_mem[m_top] : 32'd0);
    check({tag, " ptr"},    32'(cur_ptr), 32'(m_top));
    check({tag, " cnt"},    32'(cur_cnt), 32'(m_cnt));
  endtask

  // Drive one cycle from a negedge, update the model at the edge, return at next negedge
  task automatic step(input logic fv, st, call, ret, fl,
                      input logic [31:0] pc, input logic [2:0] fp, input logic [3:0] fc);
    fetch_valid = fv; stall = st; is_call = call; is_return = ret;
    flush = fl; fetch_pc = pc; flush_ptr = fp; flush_cnt = fc;
    @(posedge clk);
    model_step(fv, st, call, ret, fl, pc, int'(fp), int'(fc));
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    fetch_valid = 0; stall = 0; is_call = 0; is_return = 0; flush = 0;
    rst_n = 1'b0;
    model_reset();
    #2;
    check("reset valid",  32'(ras_valid), 32'd0);
    check("reset target", ras_target, 32'd0);
    check("reset ptr",    32'(cur_ptr), 32'd0);
    check("reset cnt",    32'(cur_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        fv, st, call, ret;
    logic [31:0] pc;
    logic        exp_v;
    logic [31:0] exp_t;
    int          exp_ptr, exp_cnt;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input logic fv, st, call, ret, input logic [31:0] pc,
                              input logic v, input logic [31:0] t, input int p, input int c);
    vec_t r;
    r.fv = fv; r.st = st; r.call = call; r.ret = ret; r.pc = pc;
    r.exp_v = v; r.exp_t = t; r.exp_ptr = p; r.exp_cnt = c;
    return r;
  endfunction

  ras_ckpt_t ck;

  initial begin
    //            fv st ca re pc            v  target        ptr cnt
    vecs[0]  = mk(1, 0, 0, 1, 32'h100,      0, 32'h0,        0, 0); // pop when empty
    vecs[1]  = mk(1, 0, 1, 0, 32'h400,      1, 32'h408,      1, 1);
    vecs[2]  = mk(1, 0, 0, 1, 32'h404,      0, 32'h0,        0, 0);
    vecs[3]  = mk(1, 0, 1, 0, 32'h500,      1, 32'h508,      1, 1);
    vecs[4]  = mk(1, 0, 1, 1, 32'h2000,     1, 32'h2008,     1, 1); // replace top
    vecs[5]  = mk(1, 0, 0, 1, 32'h2004,     0, 32'h0,        0, 0);
    vecs[6]  = mk(1, 0, 1, 1, 32'h2000,     1, 32'h2008,     1, 1); // empty: plain push
    vecs[7]  = mk(1, 1, 1, 0, 32'h3000,     1, 32'h2008,     1, 1); // stalled
    vecs[8]  = mk(1, 0, 1, 0, 32'h3000,     1, 32'h3008,     2, 2);
    vecs[9]  = mk(0, 0, 1, 0, 32'h4000,     1, 32'h3008,     2, 2); // not valid
    vecs[10] = mk(1, 0, 0, 1, 32'h3004,     1, 32'h2008,     1, 1);
    vecs[11] = mk(1, 0, 0, 1, 32'h3008,     0, 32'h0,        0, 0);
    vecs[12] = mk(1, 0, 1, 0, 32'hFFFFFFFC, 1, 32'h4,        1, 1); // PC wrap
    vecs[13] = mk(1, 0, 0, 1, 32'h4,        0, 32'h0,        0, 0);

    model_reset();
    do_reset();

    // Table-driven directed vectors
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].fv, vecs[i].st, vecs[i].call, vecs[i].ret, 1'b0, vecs[i].pc, 3'd0, 4'd0);
      check($sformatf("vec%0d valid", i),  32'(ras_valid), 32'(vecs[i].exp_v));
      check($sformatf("vec%0d target", i), ras_target, vecs[i].exp_t);
      check($sformatf("vec%0d ptr", i),    32'(cur_ptr), 32'(vecs[i].exp_ptr));
      check($sformatf("vec%0d cnt", i),    32'(cur_cnt), 32'(vecs[i].exp_cnt));
    end

    // Overflow: 9 calls into 8 entries, then drain
    do_reset();
    for (int i = 0; i < 9; i++) step(1, 0, 1, 0, 0, 32'h1000 + 32'(i * 16), 3'd0, 4'd0);
    check("ovf cnt",    32'(cur_cnt), 32'd8);
    check("ovf target", ras_target, 32'h1088);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain%0d target", k), ras_target, 32'h1088 - 32'(k * 16));
      step(1, 0, 0, 1, 0, 32'h9000, 3'd0, 4'd0);
    end
    check("drained valid", 32'(ras_valid), 32'd0);
    step(1, 0, 0, 1, 0, 32'h9000, 3'd0, 4'd0);
    check("ninth pop valid", 32'(ras_valid), 32'd0);
    check("ninth pop cnt",   32'(cur_cnt), 32'd0);

    // Flush recovery with a call in the flush cycle
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 32'h6000 + 32'(i * 16), 3'd0, 4'd0);
    ck.ptr = cur_ptr;
    ck.cnt = cur_cnt;
    step(1, 0, 1, 0, 0, 32'h6030, 3'd0, 4'd0);
    step(1, 0, 1, 0, 0, 32'h6040, 3'd0, 4'd0);
    step(1, 1, 1, 0, 1, 32'h7000, ck.ptr, ck.cnt);
`ifdef RAS_CHECKPOINT_EN
    check("flush target", ras_target, 32'h6028);
    check("flush cnt",    32'(cur_cnt), 32'd3);
    check("flush ptr",    32'(cur_ptr), 32'd3);
    step(0, 0, 0, 0, 1, 32'h0, 3'd6, 4'd15);
    check("flush clamp cnt", 32'(cur_cnt), 32'd8);
    check("flush clamp ptr", 32'(cur_ptr), 32'd6);
`else
    check("flush cnt",   32'(cur_cnt), 32'd0);
    check("flush valid", 32'(ras_valid), 32'd0);
    check("flush ptr",   32'(cur_ptr), 32'd0);
`endif
    check_model("flush model");

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 15) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                         : ($urandom & 32'hFFFFFFFC);
      step($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0,
           1'($urandom), 1'($urandom), $urandom_range(0, 24) == 0,
           pc, 3'($urandom), 4'($urandom_range(0, 15)));
      check_model($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
